// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial bit-pattern detector (KMP automaton).
// It accepts one bit per cycle while en is high. The first pattern bit
// received is PATTERN[PAT_LEN-1].
//
// Parameters
//   PAT_LEN  : pattern length in bits (legal range 2..16)
//   PATTERN  : pattern to detect, MSB received first
//   OVERLAP  : 1 = overlapping matches count, 0 = restart from empty after a match
//   CNT_W    : width of the saturating match counter
//   STATE_W  : derived width of state; leave at its default
//
// Ports
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset, highest priority
//   x           : serial data bit
//   en          : x is valid this cycle; when low, all state holds
//   clr_cnt     : synchronous clear of match_count (wins over an increment)
//   state       : matched-prefix length, 0..PAT_LEN-1 (registered)
//   y           : registered (Moore) match pulse, one cycle after the final bit
//   y_mealy     : combinational (Mealy) match, same cycle as the final bit
//   match_count : saturating count of matches
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    parameter int                 STATE_W = $clog2(PAT_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               en,
    input  logic               clr_cnt,
    output logic [STATE_W-1:0] state,
    output logic               y,
    output logic               y_mealy,
    output logic [CNT_W-1:0]   match_count
);

    // Pattern bit i in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int i);
        return PATTERN[PAT_LEN-1-i];
    endfunction

    // Longest prefix of the pattern, capped at PAT_LEN-1, that is a suffix of
    // (first k pattern bits followed by b). Evaluated only at elaboration
    // time, so the fallback table follows PATTERN automatically.
    function automatic int fallback(input int k, input logic b);
        int   best;
        int   pos;
        logic ok;
        logic s_bit;
        best = 0;
        for (int len = 1; len <= PAT_LEN - 1; len++) begin
            if (len <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < len; i++) begin
                    pos   = k + 1 - len + i;
                    s_bit = (pos == k) ? b : pat_bit(pos);
                    if (s_bit != pat_bit(i)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = len;
                end
            end
        end
        return best;
    endfunction

    localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(PAT_LEN - 1);
    // After the final bit of a match the automaton resumes from the longest
    // proper border of the pattern; with overlap disabled it starts empty.
    localparam logic [STATE_W-1:0] BORDER     = STATE_W'(fallback(PAT_LEN - 1, PATTERN[0]));
    localparam logic [STATE_W-1:0] RESTART    = OVERLAP ? BORDER : '0;
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    logic               y_reg;
    logic               y_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               match;

    // Next-state tables, one entry per state for each value of x.
    logic [STATE_W-1:0] nxt0_tab [PAT_LEN];
    logic [STATE_W-1:0] nxt1_tab [PAT_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < PAT_LEN; gi++) begin : g_fallback
            localparam logic [STATE_W-1:0] F0 = STATE_W'(fallback(gi, 1'b0));
            localparam logic [STATE_W-1:0] F1 = STATE_W'(fallback(gi, 1'b1));
            assign nxt0_tab[gi] = F0;
            assign nxt1_tab[gi] = F1;
        end
    endgenerate

    // Reset is folded in so y_mealy stays low while reset is asserted.
    assign match = en && !reset && (state_reg == LAST_STATE) && (x == PATTERN[0]);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        // With en low, match is 0, so y drops and a pulse is never stretched.
        y_next     = match;

        if (en) begin
            if (match) begin
                state_next = RESTART;
            end else if (x) begin
                state_next = nxt1_tab[state_reg];
            end else begin
                state_next = nxt0_tab[state_reg];
            end
        end

        if (clr_cnt) begin
            cnt_next = '0;
        end else if (match && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= '0;
            y_reg     <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign state       = state_reg;
    assign y           = y_reg;
    assign y_mealy     = match;
    assign match_count = cnt_reg;

endmodule
